// File: rtl/spike_window_classifier.sv
// Per-class spike counting over a programmable window, followed by a
// one-class-per-cycle argmax scan that reports winner, count, margin and no-spike.

module spike_class_counter #(
  parameter int COUNT_W = 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               inc_i,
  output logic [COUNT_W-1:0] count_o
);
  logic [COUNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) count_d = '0;
    else if (inc_i && (count_q != '1)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;
endmodule

module spike_window_classifier #(
  parameter int NUM_CLASSES = 10,
  parameter int COUNT_W     = 6,
  parameter int WINDOW_W    = 8,
  parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [WINDOW_W-1:0]    window_len_i,
  input  logic [NUM_CLASSES-1:0] spike_i,
  output logic                   busy_o,
  output logic                   result_valid_o,
  input  logic                   result_ready_i,
  output logic [IDX_W-1:0]       predicted_o,
  output logic [COUNT_W-1:0]     max_count_o,
  output logic [COUNT_W-1:0]     margin_o,
  output logic                   no_spike_o
);
  typedef enum logic [1:0] {IDLE, COUNT, SCAN, HOLD} state_e;

  state_e                              state_q, state_d;
  logic [WINDOW_W-1:0]                 remaining_q, remaining_d;
  logic [IDX_W-1:0]                    scan_idx_q, scan_idx_d;
  logic [COUNT_W-1:0]                  best_q, best_d, second_q, second_d;
  logic [IDX_W-1:0]                    best_idx_q, best_idx_d;
  logic [IDX_W-1:0]                    predicted_q, predicted_d;
  logic [COUNT_W-1:0]                  max_count_q, max_count_d;
  logic [COUNT_W-1:0]                  margin_q, margin_d;
  logic                                no_spike_q, no_spike_d;
  logic                                valid_q, valid_d;
  logic                                busy_q, busy_d;
  logic                                clr, cnt_en;
  logic [NUM_CLASSES-1:0][COUNT_W-1:0] counts;
  logic [COUNT_W-1:0]                  cur_cnt, nb, ns;
  logic [IDX_W-1:0]                    nbi;

  for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_lane
    spike_class_counter #(.COUNT_W(COUNT_W)) u_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (clr),
      .inc_i   (cnt_en & spike_i[g]),
      .count_o (counts[g])
    );
  end

  // Index compare instead of direct select keeps non-power-of-two class counts in range.
  always_comb begin
    cur_cnt = '0;
    for (int k = 0; k < NUM_CLASSES; k++)
      if (scan_idx_q == IDX_W'(k)) cur_cnt = counts[k];
  end

  // Strict '>' keeps the lowest index on ties; an equal count still lifts second.
  always_comb begin
    nb  = best_q;
    ns  = second_q;
    nbi = best_idx_q;
    if (cur_cnt > best_q) begin
      ns  = best_q;
      nb  = cur_cnt;
      nbi = scan_idx_q;
    end else if (cur_cnt > second_q) begin
      ns = cur_cnt;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    scan_idx_d  = scan_idx_q;
    best_d      = best_q;
    second_d    = second_q;
    best_idx_d  = best_idx_q;
    predicted_d = predicted_q;
    max_count_d = max_count_q;
    margin_d    = margin_q;
    no_spike_d  = no_spike_q;
    valid_d     = valid_q;
    clr         = 1'b0;
    cnt_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          clr         = 1'b1;
          remaining_d = window_len_i;
          state_d     = COUNT;
        end
      end
      COUNT: begin
        cnt_en      = 1'b1;
        // A loaded 0 wraps to all-ones, giving a full 2^WINDOW_W window.
        remaining_d = remaining_q - 1'b1;
        if (remaining_q == WINDOW_W'(1)) begin
          state_d    = SCAN;
          scan_idx_d = '0;
          best_d     = '0;
          second_d   = '0;
          best_idx_d = '0;
        end
      end
      SCAN: begin
        best_d     = nb;
        second_d   = ns;
        best_idx_d = nbi;
        scan_idx_d = scan_idx_q + 1'b1;
        if (scan_idx_q == IDX_W'(NUM_CLASSES - 1)) begin
          predicted_d = nbi;
          max_count_d = nb;
          margin_d    = nb - ns;
          no_spike_d  = (nb == '0);
          valid_d     = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (valid_q && result_ready_i) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      scan_idx_q  <= '0;
      best_q      <= '0;
      second_q    <= '0;
      best_idx_q  <= '0;
      predicted_q <= '0;
      max_count_q <= '0;
      margin_q    <= '0;
      no_spike_q  <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      scan_idx_q  <= scan_idx_d;
      best_q      <= best_d;
      second_q    <= second_d;
      best_idx_q  <= best_idx_d;
      predicted_q <= predicted_d;
      max_count_q <= max_count_d;
      margin_q    <= margin_d;
      no_spike_q  <= no_spike_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
    end
  end

  assign busy_o         = busy_q;
  assign result_valid_o = valid_q;
  assign predicted_o    = predicted_q;
  assign max_count_o    = max_count_q;
  assign margin_o       = margin_q;
  assign no_spike_o     = no_spike_q;
endmodule
